// File: rtl/way_select_controller.sv
// Cache way-select sequencer: resolves hit way or a tree-PLRU victim per lookup and keeps per-set PLRU state.
// Optional STATS_EN adds hit_count/miss_count outputs.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready=1
// LOOKUP | one cycle: resolve way, update the set's PLRU tree
// RESP   | result presented until resp_ready
module way_select_controller #(
   parameter int ways = 8,
   parameter int sets = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [$clog2(sets)-1:0]   req_set,
   input  logic [ways-1:0]           req_hit_vec,
   input  logic [ways-1:0]           req_valid_vec,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic                      resp_hit,
   output logic [$clog2(ways)-1:0]   resp_way,
   output logic                      resp_multi_hit
`ifdef STATS_EN
   ,
   output logic [31:0]               hit_count,
   output logic [31:0]               miss_count
`endif
);

   localparam int WW = $clog2(ways);
   localparam int SW = $clog2(sets);

   typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

   state_t           state;
   logic [SW-1:0]    set_q;
   logic [ways-1:0]  hit_q;
   logic [ways-1:0]  valid_q;
   // Heap-ordered tree: node 1 is the root, children of n are 2n and 2n+1.
   logic [ways-1:1]  plru [sets];

   logic [ways-1:1]  tree_old;
   logic [ways-1:1]  tree_new;
   logic [WW-1:0]    node;
   logic [WW-1:0]    walk;
   logic             b;
   logic             nxt_hit;
   logic             nxt_multi;
   logic [WW-1:0]    nxt_way;

   always_comb begin
      tree_old  = plru[set_q];
      tree_new  = tree_old;
      nxt_hit   = |hit_q;
      nxt_multi = ($countones(hit_q) > 1);
      nxt_way   = '0;
      node      = WW'(1);
      walk      = '0;
      b         = 1'b0;
      if (nxt_hit) begin
         for (int i = ways - 1; i >= 0; i--)
            if (hit_q[i]) nxt_way = WW'(i);
      end else if (!(&valid_q)) begin
         for (int i = ways - 1; i >= 0; i--)
            if (!valid_q[i]) nxt_way = WW'(i);
      end else begin
         for (int l = 0; l < WW; l++) begin
            b       = tree_old[node];
            nxt_way = (nxt_way << 1) | WW'(b);
            node    = (node << 1) | WW'(b);
         end
      end
      // Point every node on the chosen way's path away from it.
      node = WW'(1);
      walk = nxt_way;
      for (int l = 0; l < WW; l++) begin
         b              = walk[WW-1];
         tree_new[node] = ~b;
         node           = (node << 1) | WW'(b);
         walk           = walk << 1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_hit       <= 1'b0;
         resp_way       <= '0;
         resp_multi_hit <= 1'b0;
         set_q          <= '0;
         hit_q          <= '0;
         valid_q        <= '0;
         for (int s = 0; s < sets; s++) plru[s] <= '0;
`ifdef STATS_EN
         hit_count      <= '0;
         miss_count     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  set_q     <= req_set;
                  hit_q     <= req_hit_vec;
                  valid_q   <= req_valid_vec;
                  req_ready <= 1'b0;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               resp_hit       <= nxt_hit;
               resp_way       <= nxt_way;
               resp_multi_hit <= nxt_multi;
               resp_valid     <= 1'b1;
               plru[set_q]    <= tree_new;
`ifdef STATS_EN
               if (nxt_hit) hit_count  <= hit_count + 32'd1;
               else         miss_count <= miss_count + 32'd1;
`endif
               state          <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
